// File: rtl/adc_frame_smoother_if.sv
// Frame bundle between the SPI receiver side and the smoother: raw words and
// the frame flag travel in, smoothed words and status flags travel out.
interface adc_frame_smoother_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] i_data0;
  logic [DATA_WIDTH-1:0] i_data1;
  logic                  i_data_received;
  logic [DATA_WIDTH-1:0] o_data0;
  logic [DATA_WIDTH-1:0] o_data1;
  logic                  o_valid;
  logic                  o_stale;
  logic                  o_overrun;

  modport master (
    output i_data0, i_data1, i_data_received,
    input  o_data0, o_data1, o_valid, o_stale, o_overrun
  );

  modport slave (
    input  i_data0, i_data1, i_data_received,
    output o_data0, o_data1, o_valid, o_stale, o_overrun
  );
endinterface

// File: rtl/adc_frame_smoother.sv
// Captures two-word ADC frames from the SPI clock domain, smooths each channel
// with a first-order IIR and reports stale input and frame overruns.
module adc_frame_smoother #(
  parameter int DATA_WIDTH     = 16,
  parameter int SMOOTH_SHIFT   = 3,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  adc_frame_smoother_if.slave bus
);

  localparam int ACC_W = DATA_WIDTH + SMOOTH_SHIFT;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FILTER0, FILTER1, OUTPUT} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, sync3_q;
  logic                  frameEdge;
  logic                  captureEn, filter0En, filter1En, outputEn;
  logic [DATA_WIDTH-1:0] capture0_q, capture1_q;
  logic                  preload_q;
  logic [ACC_W-1:0]      accum0_q, accum0_d;
  logic [ACC_W-1:0]      accum1_q, accum1_d;
  logic [SUM_W-1:0]      accum0Sum, accum1Sum;
  logic [CNT_W-1:0]      timeout_q, timeout_d;
  logic                  stale_q, stale_d;
  logic                  overrun_q, overrun_d;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data0_q, data1_q;

  // Two flops resolve metastability, the third gives a clean rising-edge detect.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.i_data_received;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign frameEdge = sync2_q & ~sync3_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frameEdge) state_d = FILTER0;
      FILTER0: state_d = FILTER1;
      FILTER1: state_d = OUTPUT;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    captureEn = 1'b0;
    filter0En = 1'b0;
    filter1En = 1'b0;
    outputEn  = 1'b0;
    case (state_q)
      IDLE:    captureEn = frameEdge;
      FILTER0: filter0En = 1'b1;
      FILTER1: filter1En = 1'b1;
      OUTPUT:  outputEn  = 1'b1;
      default: ;
    endcase
  end

  // Stale looks one count ahead so a capture on the saturating cycle still preloads.
  always_comb begin
    if (captureEn) begin
      timeout_d = '0;
    end else if (timeout_q == CNT_LIMIT) begin
      timeout_d = timeout_q;
    end else begin
      timeout_d = timeout_q + CNT_W'(1);
    end

    stale_d = stale_q;
    if (timeout_q >= CNT_NEAR) begin
      stale_d = 1'b1;
    end
    if (outputEn) begin
      stale_d = 1'b0;
    end

    overrun_d = overrun_q | (frameEdge & (state_q != IDLE));
  end

  // The extra top bit keeps acc + sample from wrapping before the decay is removed.
  always_comb begin
    accum0Sum = SUM_W'(accum0_q) + SUM_W'(capture0_q) - SUM_W'(accum0_q >> SMOOTH_SHIFT);
    accum1Sum = SUM_W'(accum1_q) + SUM_W'(capture1_q) - SUM_W'(accum1_q >> SMOOTH_SHIFT);
    accum0_d  = preload_q ? (ACC_W'(capture0_q) << SMOOTH_SHIFT) : ACC_W'(accum0Sum);
    accum1_d  = preload_q ? (ACC_W'(capture1_q) << SMOOTH_SHIFT) : ACC_W'(accum1Sum);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      capture0_q <= '0;
      capture1_q <= '0;
      preload_q  <= 1'b0;
      accum0_q   <= '0;
      accum1_q   <= '0;
      timeout_q  <= '0;
      stale_q    <= 1'b1;
      overrun_q  <= 1'b0;
      valid_q    <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
    end else begin
      timeout_q <= timeout_d;
      stale_q   <= stale_d;
      overrun_q <= overrun_d;
      valid_q   <= outputEn;

      if (captureEn) begin
        capture0_q <= bus.i_data0;
        capture1_q <= bus.i_data1;
        preload_q  <= stale_d;
      end else if (outputEn) begin
        preload_q  <= 1'b0;
      end

      if (filter0En) begin
        accum0_q <= accum0_d;
      end
      if (filter1En) begin
        accum1_q <= accum1_d;
      end

      if (outputEn) begin
        data0_q <= accum0_q[ACC_W-1:SMOOTH_SHIFT];
        data1_q <= accum1_q[ACC_W-1:SMOOTH_SHIFT];
      end
    end
  end

  assign bus.o_data0   = data0_q;
  assign bus.o_data1   = data1_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_stale   = stale_q;
  assign bus.o_overrun = overrun_q;

endmodule
